multiway_data_array: RTL and testbench
======================================

# multiway_data_array

Parametrised N-way cache data store with per-byte write masks, registered reads of every way in parallel, and an integrated burst fill engine that assembles a full line from memory beats before committing it. Sits in the cache datapath between the tag/hit logic, which selects one way from the read output, and the memory-side line adapter that supplies the fill beats.

## Interface
- S_OFFSET, 5: log2 bytes per line; s_mask = 2**S_OFFSET, s_line = 8*s_mask
- S_INDEX, 3: log2 sets; num_sets = 2**S_INDEX
- NUM_WAYS, 4: ways, power of two ≥ 2; s_way = log2(NUM_WAYS)
- BEAT_W, 64: fill beat width; s_line % BEAT_W == 0; num_beats = s_line/BEAT_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- rd_en  in  1  read request
- rd_index  in  S_INDEX  set to read
- rd_data  out  NUM_WAYS*s_line  way w occupies [s_line*w +: s_line]
- rd_valid  out  1  rd_data reflects a request from the previous cycle
- wr_en  in  1  masked write request
- wr_ready  out  1  write port available (low only in COMMIT)
- wr_way  in  s_way; wr_index  in  S_INDEX; wr_mask  in  s_mask; wr_data  in  s_line
- fill_start  in  1  begin line fill
- fill_way  in  s_way; fill_index  in  S_INDEX  target, latched on accepted fill_start
- fill_beat_valid  in  1; fill_beat_data  in  BEAT_W  one beat per valid cycle
- fill_busy  out  1  fill in progress (COLLECT or COMMIT)
- fill_done  out  1  one-cycle pulse, line committed this cycle

## Operation
- Storage: NUM_WAYS × num_sets lines, all zero after reset.
- Read: rd_en captures every way of rd_index into rd_data register; rd_en=0 holds rd_data and clears rd_valid.
- Write: wr_en && wr_ready updates byte i of (wr_way, wr_index) iff wr_mask[i]; other bytes unchanged. wr_en while !wr_ready is dropped, not queued; requester retries.
- Fill FSM, states IDLE, COLLECT, COMMIT:
  - IDLE: fill_start latches fill_way/fill_index, clears beat counter → COLLECT. fill_beat_valid ignored.
  - COLLECT: each fill_beat_valid writes beat into buffer bits [BEAT_W*k +: BEAT_W], k = counter, counter++; on beat num_beats-1 → COMMIT. fill_start ignored.
  - COMMIT: full line (all bytes) written to latched way/index; fill_done=1; wr_ready=0; → IDLE.
- fill_busy = (state != IDLE). Back-to-back fills: fill_start accepted first cycle back in IDLE.
- Fill target way/index may match an in-flight CPU write; CPU writes during COLLECT land in the array and are overwritten at COMMIT.

## Timing
- Reset values: rd_data 0, rd_valid 0, fill_busy 0, fill_done 0, wr_ready 1, state IDLE, counter 0, buffer 0.
- rst mid-fill: abandons fill, no fill_done, array cleared.
- Read latency 1: rd_en at cycle N → rd_valid and rd_data at N+1.
- Write visible to a read issued the following cycle.
- Same-cycle read and write (or COMMIT) to same index: behaviour per Configuration.
- Fill: fill_start at N, beats at N+1.. (gaps allowed), last beat at M → COMMIT and fill_done at M+1, line readable by rd_en at M+2 (M+1 with bypass).

## Configuration
- DATA_ARRAY_BYPASS_EN defined: write-first; a read coinciding with a write/commit to the same index returns new bytes for written bytes of the targeted way, old bytes elsewhere.
- Undefined: read-first; coinciding read returns pre-write contents.

## Structure
- data_array_pkg: fill_state_t enum (IDLE, COLLECT, COMMIT); helper function merging bytes under a mask.
- Sub-module data_way_bank: one way's num_sets×s_line byte-masked register array with registered read and optional bypass, instantiated NUM_WAYS times; fill engine and write-port arbitration at top.

## Test plan
- Reset then rd_en index 5 → rd_valid=1, rd_data all zero at next cycle.
- wr_way 2, index 3, mask 0x0000000F, data bytes 0xAA → read index 3: way 2 low 4 bytes 0xAA, rest zero, other ways zero.
- Fill way 1 index 7, beats 0x1111…,0x2222…,0x3333…,0x4444… with one idle gap → fill_done once, line = beats in order k=0 at LSB, wr_en during COMMIT dropped.
- Same-cycle write 0xFF mask all and read same set → old data without macro, 0xFF with DATA_ARRAY_BYPASS_EN.
- rst after 2 of 4 beats → fill_busy 0, no fill_done, later stray beats ignored, array zero.
- fill_start while busy, extra beat in IDLE → ignored, single fill committed.

Source files
------------

// File: rtl/multiway_data_array_pkg.sv
// Shared types and helpers for the multi-way cache data array.
package multiway_data_array_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } fill_state_t;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       sel);
    merge_byte = sel ? new_b : old_b;
  endfunction

endpackage

// File: rtl/multiway_data_array_if.sv
// Read, masked-write and fill ports of the multi-way data array.
interface multiway_data_array_if #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4,
  parameter int BEAT_W   = 64
);
  localparam int S_MASK = 2 ** S_OFFSET;
  localparam int S_LINE = 8 * S_MASK;
  localparam int S_WAY  = $clog2(NUM_WAYS);

  logic                       rd_en;
  logic [S_INDEX-1:0]         rd_index;
  logic [NUM_WAYS*S_LINE-1:0] rd_data;
  logic                       rd_valid;
  logic                       wr_en;
  logic                       wr_ready;
  logic [S_WAY-1:0]           wr_way;
  logic [S_INDEX-1:0]         wr_index;
  logic [S_MASK-1:0]          wr_mask;
  logic [S_LINE-1:0]          wr_data;
  logic                       fill_start;
  logic [S_WAY-1:0]           fill_way;
  logic [S_INDEX-1:0]         fill_index;
  logic                       fill_beat_valid;
  logic [BEAT_W-1:0]          fill_beat_data;
  logic                       fill_busy;
  logic                       fill_done;

  modport master (
    output rd_en, rd_index, wr_en, wr_way, wr_index, wr_mask, wr_data,
           fill_start, fill_way, fill_index, fill_beat_valid, fill_beat_data,
    input  rd_data, rd_valid, wr_ready, fill_busy, fill_done
  );

  modport slave (
    input  rd_en, rd_index, wr_en, wr_way, wr_index, wr_mask, wr_data,
           fill_start, fill_way, fill_index, fill_beat_valid, fill_beat_data,
    output rd_data, rd_valid, wr_ready, fill_busy, fill_done
  );
endinterface

// File: rtl/multiway_data_array_way_bank.sv
// One way: byte-masked line storage with a registered read port.
// DATA_ARRAY_BYPASS_EN selects write-first reads on a same-index collision.
module multiway_data_array_way_bank
  import multiway_data_array_pkg::*;
#(
  parameter  int S_OFFSET = 5,
  parameter  int S_INDEX  = 3,
  localparam int S_MASK   = 2 ** S_OFFSET,
  localparam int S_LINE   = 8 * S_MASK,
  localparam int NUM_SETS = 2 ** S_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [S_INDEX-1:0] wr_index,
  input  logic [S_MASK-1:0]  wr_mask,
  input  logic [S_LINE-1:0]  wr_data,
  input  logic               re,
  input  logic [S_INDEX-1:0] rd_index,
  output logic [S_LINE-1:0]  rd_data
);

  logic [S_LINE-1:0] mem_q [NUM_SETS];
  logic [S_LINE-1:0] mem_d [NUM_SETS];
  logic [S_LINE-1:0] rd_data_q, rd_data_d;
  logic [S_LINE-1:0] line_new_s;
  logic [S_LINE-1:0] rd_line_s;

  // Merge the write into the addressed line and choose the line a read sees.
  always_comb begin
    line_new_s = '0;
    for (int i = 0; i < S_MASK; i++) begin
      line_new_s[8*i +: 8] = merge_byte(mem_q[wr_index][8*i +: 8],
                                        wr_data[8*i +: 8], wr_mask[i]);
    end
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_index] = line_new_s;
    end else begin
      mem_d = mem_q;
    end
`ifdef DATA_ARRAY_BYPASS_EN
    if (we && (wr_index == rd_index)) begin
      rd_line_s = line_new_s;
    end else begin
      rd_line_s = mem_q[rd_index];
    end
`else
    rd_line_s = mem_q[rd_index];
`endif
    if (re) begin
      rd_data_d = rd_line_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Storage and read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/multiway_data_array.sv
// N-way cache data array with a burst fill engine that commits whole lines.
// Build with DATA_ARRAY_BYPASS_EN for write-first same-index reads.
module multiway_data_array
  import multiway_data_array_pkg::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4,
  parameter int BEAT_W   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  multiway_data_array_if.slave  bus
);

  localparam int S_MASK    = 2 ** S_OFFSET;
  localparam int S_LINE    = 8 * S_MASK;
  localparam int S_WAY     = $clog2(NUM_WAYS);
  localparam int NUM_BEATS = S_LINE / BEAT_W;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  fill_state_t        state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [S_LINE-1:0]  buf_q, buf_d;
  logic [S_WAY-1:0]   fill_way_q, fill_way_d;
  logic [S_INDEX-1:0] fill_index_q, fill_index_d;
  logic               rd_valid_q, rd_valid_d;
  wire logic [NUM_WAYS*S_LINE-1:0] rd_data_s;

  // Fill engine next state: latch target, gather beats, commit the line.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    buf_d        = buf_q;
    fill_way_d   = fill_way_q;
    fill_index_d = fill_index_q;
    rd_valid_d   = bus.rd_en;
    case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          state_d      = COLLECT;
          fill_way_d   = bus.fill_way;
          fill_index_d = bus.fill_index;
          beat_cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (bus.fill_beat_valid) begin
          for (int k = 0; k < NUM_BEATS; k++) begin
            if (beat_cnt_q == CNT_W'(k)) begin
              buf_d[BEAT_W*k +: BEAT_W] = bus.fill_beat_data;
            end else begin
              buf_d[BEAT_W*k +: BEAT_W] = buf_q[BEAT_W*k +: BEAT_W];
            end
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = COMMIT;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill engine and read-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      buf_q        <= '0;
      fill_way_q   <= '0;
      fill_index_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      buf_q        <= buf_d;
      fill_way_q   <= fill_way_d;
      fill_index_q <= fill_index_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    localparam logic [S_WAY-1:0] WAY_ID = S_WAY'(w);
    logic               we_s;
    logic [S_INDEX-1:0] idx_s;
    logic [S_MASK-1:0]  mask_s;
    logic [S_LINE-1:0]  data_s;

    // The committing fill owns the write port; CPU writes are dropped then.
    always_comb begin
      if (state_q == COMMIT) begin
        we_s   = (fill_way_q == WAY_ID);
        idx_s  = fill_index_q;
        mask_s = '1;
        data_s = buf_q;
      end else begin
        we_s   = bus.wr_en && (bus.wr_way == WAY_ID);
        idx_s  = bus.wr_index;
        mask_s = bus.wr_mask;
        data_s = bus.wr_data;
      end
    end

    multiway_data_array_way_bank #(
      .S_OFFSET (S_OFFSET),
      .S_INDEX  (S_INDEX)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (we_s),
      .wr_index (idx_s),
      .wr_mask  (mask_s),
      .wr_data  (data_s),
      .re       (bus.rd_en),
      .rd_index (bus.rd_index),
      .rd_data  (rd_data_s[S_LINE*w +: S_LINE])
    );
  end

  assign bus.rd_data   = rd_data_s;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.fill_busy = (state_q != IDLE);
  assign bus.fill_done = (state_q == COMMIT);
  assign bus.wr_ready  = (state_q != COMMIT);

endmodule

// File: tb/tb_multiway_data_array.sv
// Directed self-checking bench for multiway_data_array (default 4 ways, 32-byte lines).
module tb_multiway_data_array;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multiway_data_array_if bus ();

  multiway_data_array dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] way_line(input int w);
    way_line = bus.rd_data[256*w +: 256];
  endfunction

  logic [255:0] ones;
  logic [255:0] fill_a;
  logic [255:0] fill_b;
  logic [255:0] same_cycle_exp;

  initial begin
    checks   = 0;
    failures = 0;
    ones     = {256{1'b1}};
    fill_a   = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    fill_b   = 256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001;
`ifdef DATA_ARRAY_BYPASS_EN
    same_cycle_exp = {256{1'b1}};
`else
    same_cycle_exp = 256'h00000000000000000000000000000000000000000000000000000000AAAAAAAA;
`endif

    rst = 1'b1;
    bus.rd_en = 1'b0;           bus.rd_index = 3'd0;
    bus.wr_en = 1'b0;           bus.wr_way = 2'd0;     bus.wr_index = 3'd0;
    bus.wr_mask = 32'd0;        bus.wr_data = 256'd0;
    bus.fill_start = 1'b0;      bus.fill_way = 2'd0;   bus.fill_index = 3'd0;
    bus.fill_beat_valid = 1'b0; bus.fill_beat_data = 64'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_rd_valid", 256'(bus.rd_valid), 256'd0);
    chk("reset_rd_data_w0", way_line(0), 256'd0);
    chk("reset_fill_busy", 256'(bus.fill_busy), 256'd0);
    chk("reset_fill_done", 256'(bus.fill_done), 256'd0);
    chk("reset_wr_ready", 256'(bus.wr_ready), 256'd1);

    // Read after reset
    bus.rd_en = 1'b1; bus.rd_index = 3'd5;
    tick();
    bus.rd_en = 1'b0;
    chk("read5_valid", 256'(bus.rd_valid), 256'd1);
    chk("read5_w3", way_line(3), 256'd0);
    tick();
    chk("idle_valid_low", 256'(bus.rd_valid), 256'd0);

    // Masked write of low 4 bytes
    bus.wr_en = 1'b1; bus.wr_way = 2'd2; bus.wr_index = 3'd3;
    bus.wr_mask = 32'h0000000F; bus.wr_data = {32{8'hAA}};
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1; bus.rd_index = 3'd3;
    tick();
    bus.rd_en = 1'b0;
    chk("mask_w2", way_line(2), 256'h00000000000000000000000000000000000000000000000000000000AAAAAAAA);
    chk("mask_w0", way_line(0), 256'd0);
    chk("mask_w1", way_line(1), 256'd0);
    chk("mask_w3", way_line(3), 256'd0);

    // Fill way 1 index 7 with a gap between beats 1 and 2
    bus.fill_start = 1'b1; bus.fill_way = 2'd1; bus.fill_index = 3'd7;
    tick();
    bus.fill_start = 1'b0;
    chk("fill_busy_collect", 256'(bus.fill_busy), 256'd1);
    bus.fill_beat_valid = 1'b1; bus.fill_beat_data = 64'h1111111111111111;
    tick();
    bus.fill_beat_data = 64'h2222222222222222;
    tick();
    bus.fill_beat_valid = 1'b0;
    tick();
    bus.fill_beat_valid = 1'b1; bus.fill_beat_data = 64'h3333333333333333;
    tick();
    chk("fill_done_early", 256'(bus.fill_done), 256'd0);
    bus.fill_beat_data = 64'h4444444444444444;
    tick();
    bus.fill_beat_valid = 1'b0;
    chk("commit_done", 256'(bus.fill_done), 256'd1);
    chk("commit_wr_ready", 256'(bus.wr_ready), 256'd0);
    chk("commit_busy", 256'(bus.fill_busy), 256'd1);
    bus.wr_en = 1'b1; bus.wr_way = 2'd1; bus.wr_index = 3'd7;
    bus.wr_mask = 32'hFFFFFFFF; bus.wr_data = {32{8'hEE}};
    tick();
    bus.wr_en = 1'b0;
    chk("post_commit_done", 256'(bus.fill_done), 256'd0);
    chk("post_commit_busy", 256'(bus.fill_busy), 256'd0);
    chk("post_commit_wr_ready", 256'(bus.wr_ready), 256'd1);
    bus.rd_en = 1'b1; bus.rd_index = 3'd7;
    tick();
    bus.rd_en = 1'b0;
    chk("fill_line_w1", way_line(1), fill_a);
    chk("fill_line_w0", way_line(0), 256'd0);

    // Same-cycle write and read of the same set
    bus.wr_en = 1'b1; bus.wr_way = 2'd2; bus.wr_index = 3'd3;
    bus.wr_mask = 32'hFFFFFFFF; bus.wr_data = {32{8'hFF}};
    bus.rd_en = 1'b1; bus.rd_index = 3'd3;
    tick();
    bus.wr_en = 1'b0;
    chk("collide_w2", way_line(2), same_cycle_exp);
    chk("collide_w0", way_line(0), 256'd0);
    tick();
    bus.rd_en = 1'b0;
    chk("after_collide_w2", way_line(2), ones);

    // Reset after 2 of 4 beats abandons the fill and clears the array
    bus.fill_start = 1'b1; bus.fill_way = 2'd3; bus.fill_index = 3'd0;
    tick();
    bus.fill_start = 1'b0;
    bus.fill_beat_valid = 1'b1; bus.fill_beat_data = 64'hAAAAAAAAAAAAAAAA;
    tick();
    tick();
    bus.fill_beat_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 256'(bus.fill_busy), 256'd0);
    chk("rst_mid_done", 256'(bus.fill_done), 256'd0);
    chk("rst_mid_wr_ready", 256'(bus.wr_ready), 256'd1);
    chk("rst_mid_rd_data", way_line(2), 256'd0);
    bus.fill_beat_valid = 1'b1; bus.fill_beat_data = 64'h5555555555555555;
    tick();
    chk("stray1_busy", 256'(bus.fill_busy), 256'd0);
    tick();
    bus.fill_beat_valid = 1'b0;
    chk("stray2_busy", 256'(bus.fill_busy), 256'd0);
    chk("stray2_done", 256'(bus.fill_done), 256'd0);
    bus.rd_en = 1'b1; bus.rd_index = 3'd7;
    tick();
    chk("cleared_7_w1", way_line(1), 256'd0);
    bus.rd_index = 3'd3;
    tick();
    chk("cleared_3_w2", way_line(2), 256'd0);
    bus.rd_index = 3'd0;
    tick();
    bus.rd_en = 1'b0;
    chk("cleared_0_w3", way_line(3), 256'd0);

    // fill_start while busy is ignored; beat in IDLE is ignored
    bus.fill_start = 1'b1; bus.fill_way = 2'd0; bus.fill_index = 3'd2;
    tick();
    bus.fill_way = 2'd3; bus.fill_index = 3'd6;
    bus.fill_beat_valid = 1'b1; bus.fill_beat_data = 64'd1;
    tick();
    bus.fill_start = 1'b0;
    bus.fill_beat_data = 64'd2;
    tick();
    bus.fill_beat_data = 64'd3;
    tick();
    bus.fill_beat_data = 64'd4;
    tick();
    bus.fill_beat_valid = 1'b0;
    chk("fill2_done", 256'(bus.fill_done), 256'd1);
    tick();
    chk("fill2_done_pulse", 256'(bus.fill_done), 256'd0);
    bus.fill_beat_valid = 1'b1; bus.fill_beat_data = 64'h99;
    tick();
    bus.fill_beat_valid = 1'b0;
    chk("idle_beat_busy", 256'(bus.fill_busy), 256'd0);
    chk("idle_beat_done", 256'(bus.fill_done), 256'd0);
    bus.rd_en = 1'b1; bus.rd_index = 3'd2;
    tick();
    chk("fill2_line_w0", way_line(0), fill_b);
    chk("fill2_line_w3", way_line(3), 256'd0);
    bus.rd_index = 3'd6;
    tick();
    bus.rd_en = 1'b0;
    chk("ignored_target_w3", way_line(3), 256'd0);
    chk("ignored_target_w0", way_line(0), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
